bft_leaf_interface: RTL and testbench

//  Leaf-side adapter between one PE and one leaf port of the 8-leaf BFT network (gen_nw8).
//  TX path: buffers PE words and drives a registered 49-bit packet onto dout_leaf.
//    Re-drives the same packet while the network asserts resend.
//  RX path: captures valid packets from din_leaf into a FIFO and presents them to the PE on a

---
 rtl/bft_leaf_interface.sv | 162 ++++++++++++++++
 tb/tb_bft_leaf_interface.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bft_leaf_interface.sv
// bft_leaf_interface
// Adapter between one PE and one leaf port of the 8-leaf BFT network.
// The TX side buffers PE words and drives a registered packet onto the leaf. It keeps
// re-driving the same packet for as long as the network rejects it with resend.
// The RX side captures valid leaf packets into a first-word-fall-through FIFO for the PE.
// The network cannot be back-pressured, so a packet that arrives while the RX FIFO is full
// is dropped and counted.
module bft_leaf_interface #(
  parameter int PAYLOAD_SZ = 45,
  parameter int ADDR_W     = 3,
  parameter int P_SZ       = 49,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PAYLOAD_SZ-1:0] tx_data,
  input  logic [ADDR_W-1:0]     tx_dest,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [P_SZ-1:0]       dout_leaf,
  input  logic                  resend,
  input  logic [P_SZ-1:0]       din_leaf,
  output logic [PAYLOAD_SZ-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overflow,
  output logic [15:0]           rx_drop_cnt
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int E_SZ  = ADDR_W + PAYLOAD_SZ;
  localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);

  // TX storage holds {dest, payload}; the valid bit is added when the word is launched.
  logic [E_SZ-1:0]       r_txMem [TX_DEPTH];
  logic [TX_AW-1:0]      r_txWrPtr;
  logic [TX_AW-1:0]      r_txRdPtr;
  logic [TX_AW:0]        r_txCount;
  logic [P_SZ-1:0]       r_doutLeaf;

  logic [PAYLOAD_SZ-1:0] r_rxMem [RX_DEPTH];
  logic [RX_AW-1:0]      r_rxWrPtr;
  logic [RX_AW-1:0]      r_rxRdPtr;
  logic [RX_AW:0]        r_rxCount;
  logic                  r_rxOverflow;
  logic [15:0]           r_rxDropCnt;

  logic                  w_txPush;
  logic                  w_txHold;
  logic                  w_txPop;
  logic [E_SZ-1:0]       w_txHead;
  logic                  w_rxIn;
  logic                  w_rxPop;
  logic                  w_rxWrite;
  logic                  w_rxDrop;
  logic                  w_unusedRxDest;

  // The destination field of a received packet carries no information for the PE.
  assign w_unusedRxDest = ^din_leaf[P_SZ-2:PAYLOAD_SZ];

  assign tx_ready  = (r_txCount != TX_FULL);
  assign w_txPush  = tx_valid && tx_ready;
  assign w_txHold  = r_doutLeaf[P_SZ-1] && resend;
  assign w_txPop   = !w_txHold && (r_txCount != '0);
  assign w_txHead  = r_txMem[r_txRdPtr];
  assign dout_leaf = r_doutLeaf;

  assign rx_valid    = (r_rxCount != '0);
  assign rx_data     = r_rxMem[r_rxRdPtr];
  assign w_rxIn      = din_leaf[P_SZ-1];
  assign w_rxPop     = rx_valid && rx_ready;
  assign w_rxWrite   = w_rxIn && ((r_rxCount != RX_FULL) || w_rxPop);
  assign w_rxDrop    = w_rxIn && !w_rxWrite;
  assign rx_overflow = r_rxOverflow;
  assign rx_drop_cnt = r_rxDropCnt;

  // TX storage write; contents are don't-care until the count says they are live.
  always_ff @(posedge clk) begin
    if (w_txPush) begin
      r_txMem[r_txWrPtr] <= {tx_dest, tx_data};
    end
  end

  // TX pointers and occupancy; a push and a pop at the same edge leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_txWrPtr <= '0;
      r_txRdPtr <= '0;
      r_txCount <= '0;
    end else begin
      if (w_txPush) begin
        r_txWrPtr <= r_txWrPtr + 1'b1;
      end
      if (w_txPop) begin
        r_txRdPtr <= r_txRdPtr + 1'b1;
      end
      if (w_txPush && !w_txPop) begin
        r_txCount <= r_txCount + 1'b1;
      end else if (!w_txPush && w_txPop) begin
        r_txCount <= r_txCount - 1'b1;
      end
    end
  end

  // Leaf output register: hold a rejected packet, otherwise launch the FIFO head or go idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_doutLeaf <= '0;
    end else if (w_txHold) begin
      r_doutLeaf <= r_doutLeaf;
    end else if (w_txPop) begin
      r_doutLeaf <= {1'b1, w_txHead};
    end else begin
      r_doutLeaf <= '0;
    end
  end

  // RX storage write; only the payload is kept.
  always_ff @(posedge clk) begin
    if (w_rxWrite) begin
      r_rxMem[r_rxWrPtr] <= din_leaf[PAYLOAD_SZ-1:0];
    end
  end

  // RX pointers and occupancy; a full FIFO still accepts when the PE pops at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxWrPtr <= '0;
      r_rxRdPtr <= '0;
      r_rxCount <= '0;
    end else begin
      if (w_rxWrite) begin
        r_rxWrPtr <= r_rxWrPtr + 1'b1;
      end
      if (w_rxPop) begin
        r_rxRdPtr <= r_rxRdPtr + 1'b1;
      end
      if (w_rxWrite && !w_rxPop) begin
        r_rxCount <= r_rxCount + 1'b1;
      end else if (!w_rxWrite && w_rxPop) begin
        r_rxCount <= r_rxCount - 1'b1;
      end
    end
  end

  // Drop bookkeeping: sticky overflow flag and a saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxOverflow <= 1'b0;
      r_rxDropCnt  <= '0;
    end else if (w_rxDrop) begin
      r_rxOverflow <= 1'b1;
      if (r_rxDropCnt != 16'hFFFF) begin
        r_rxDropCnt <= r_rxDropCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bft_leaf_interface.sv
// tb_bft_leaf_interface
// Drives the leaf adapter with directed vectors, hand-written corner sequences and random
// traffic. A queue-based reference model tracks what the PE and the network should see.
module tb_bft_leaf_interface;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [44:0] tx_data;
  logic [2:0]  tx_dest;
  logic        tx_valid;
  logic        tx_ready;
  logic [48:0] dout_leaf;
  logic        resend;
  logic [48:0] din_leaf;
  logic [44:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_overflow;
  logic [15:0] rx_drop_cnt;

  bft_leaf_interface dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_dest     (tx_dest),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .dout_leaf   (dout_leaf),
    .resend      (resend),
    .din_leaf    (din_leaf),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overflow (rx_overflow),
    .rx_drop_cnt (rx_drop_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: plain queues for both FIFOs plus the launched packet.
  logic [47:0] mTxQ[$];
  logic [44:0] mRxQ[$];
  logic [48:0] mDout = '0;
  logic        mOvf  = 1'b0;
  int          mDrop = 0;

  typedef struct {
    logic        txValid;
    logic [44:0] txData;
    logic [2:0]  txDest;
    logic        resend;
    logic [48:0] expDout;
    logic        expTxReady;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [48:0] pkt(input logic [2:0] dest, input logic [44:0] data);
    return {1'b1, dest, data};
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    bit txPush;
    bit rxPop;
    bit rxStore;
    if (reset) begin
      mTxQ.delete();
      mRxQ.delete();
      mDout = '0;
      mOvf  = 1'b0;
      mDrop = 0;
      return;
    end
    txPush = tx_valid && (mTxQ.size() < DEPTH);
    if (!(mDout[48] && resend)) begin
      if (mTxQ.size() > 0) mDout = {1'b1, mTxQ.pop_front()};
      else                 mDout = '0;
    end
    if (txPush) mTxQ.push_back({tx_dest, tx_data});
    rxPop   = rx_ready && (mRxQ.size() > 0);
    rxStore = din_leaf[48] && ((mRxQ.size() < DEPTH) || rxPop);
    if (rxPop) void'(mRxQ.pop_front());
    if (rxStore) begin
      mRxQ.push_back(din_leaf[44:0]);
    end else if (din_leaf[48]) begin
      mOvf = 1'b1;
      if (mDrop < 65535) mDrop++;
    end
  endtask

  task automatic checkOutput();
    check("dout_leaf", 64'(dout_leaf), 64'(mDout));
    check("tx_ready", 64'(tx_ready), 64'(mTxQ.size() < DEPTH));
    check("rx_valid", 64'(rx_valid), 64'(mRxQ.size() > 0));
    if (mRxQ.size() > 0) check("rx_data", 64'(rx_data), 64'(mRxQ[0]));
    check("rx_overflow", 64'(rx_overflow), 64'(mOvf));
    check("rx_drop_cnt", 64'(rx_drop_cnt), 64'(mDrop[15:0]));
  endtask

  // One clock: model and DUT both consume the applied inputs, then outputs are compared.
  task automatic applyStimulus();
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idleInputs();
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_dest  = '0;
    resend   = 1'b0;
    din_leaf = '0;
    rx_ready = 1'b0;
  endtask

  task automatic randomInputs();
    tx_valid = 1'($urandom_range(1));
    tx_data  = 45'({$urandom(), $urandom()});
    tx_dest  = 3'($urandom_range(7));
    resend   = ($urandom_range(3) == 0);
    din_leaf = 49'({$urandom(), $urandom()});
    rx_ready = 1'($urandom_range(1));
  endtask

  initial begin
    int accepted;
    reset = 1'b1;
    idleInputs();

    // Reset held two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      randomInputs();
      applyStimulus();
    end
    check("reset dout_leaf", 64'(dout_leaf), 64'(0));
    check("reset tx_ready", 64'(tx_ready), 64'(1));
    check("reset rx_valid", 64'(rx_valid), 64'(0));
    check("reset rx_overflow", 64'(rx_overflow), 64'(0));
    check("reset rx_drop_cnt", 64'(rx_drop_cnt), 64'(0));
    reset = 1'b0;
    idleInputs();
    applyStimulus();

    // Directed TX vectors: single packet, then resend holding packet A for five cycles.
    vecs.push_back('{1'b1, 45'h1234, 3'd5, 1'b0, 49'h0, 1'b1});
    vecs.push_back('{1'b0, 45'h0, 3'd0, 1'b0, pkt(3'd5, 45'h1234), 1'b1});
    vecs.push_back('{1'b0, 45'h0, 3'd0, 1'b0, 49'h0, 1'b1});
    vecs.push_back('{1'b1, 45'hAAA, 3'd1, 1'b0, 49'h0, 1'b1});
    vecs.push_back('{1'b1, 45'hBBB, 3'd2, 1'b0, pkt(3'd1, 45'hAAA), 1'b1});
    vecs.push_back('{1'b1, 45'hCCC, 3'd3, 1'b1, pkt(3'd1, 45'hAAA), 1'b1});
    vecs.push_back('{1'b0, 45'h0, 3'd0, 1'b1, pkt(3'd1, 45'hAAA), 1'b1});
    vecs.push_back('{1'b0, 45'h0, 3'd0, 1'b1, pkt(3'd1, 45'hAAA), 1'b1});
    vecs.push_back('{1'b0, 45'h0, 3'd0, 1'b1, pkt(3'd1, 45'hAAA), 1'b1});
    vecs.push_back('{1'b0, 45'h0, 3'd0, 1'b0, pkt(3'd2, 45'hBBB), 1'b1});
    vecs.push_back('{1'b0, 45'h0, 3'd0, 1'b0, pkt(3'd3, 45'hCCC), 1'b1});
    vecs.push_back('{1'b0, 45'h0, 3'd0, 1'b0, 49'h0, 1'b1});
    foreach (vecs[i]) begin
      tx_valid = vecs[i].txValid;
      tx_data  = vecs[i].txData;
      tx_dest  = vecs[i].txDest;
      resend   = vecs[i].resend;
      applyStimulus();
      check($sformatf("vec%0d dout_leaf", i), 64'(dout_leaf), 64'(vecs[i].expDout));
      check($sformatf("vec%0d tx_ready", i), 64'(tx_ready), 64'(vecs[i].expTxReady));
    end
    idleInputs();

    // TX full: network stalled, 17 words accepted (one on the leaf, sixteen buffered).
    $display("[TB] TX full sequence");
    accepted = 0;
    resend   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_valid = 1'b1;
      tx_dest  = 3'(accepted % 8);
      tx_data  = 45'(accepted + 256);
      if (mTxQ.size() < DEPTH) accepted++;
      applyStimulus();
    end
    check("txfull accepted", 64'(accepted), 64'(17));
    check("txfull tx_ready", 64'(tx_ready), 64'(0));
    check("txfull held head", 64'(dout_leaf), 64'(pkt(3'd0, 45'd256)));
    idleInputs();
    for (int j = 1; j <= 16; j++) begin
      applyStimulus();
      check($sformatf("txfull order %0d", j), 64'(dout_leaf), 64'(pkt(3'(j % 8), 45'(j + 256))));
    end
    applyStimulus();
    check("txfull drained", 64'(dout_leaf), 64'(0));

    // RX overflow: 18 packets with the PE stalled, then drain the 16 that were kept.
    $display("[TB] RX overflow sequence");
    for (int i = 0; i < 18; i++) begin
      din_leaf = {1'b1, 3'($urandom_range(7)), 45'(32'h5000 + i)};
      applyStimulus();
    end
    din_leaf = '0;
    check("rxovf flag", 64'(rx_overflow), 64'(1));
    check("rxovf drop_cnt", 64'(rx_drop_cnt), 64'(2));
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rxovf drain %0d", i), 64'({rx_valid, rx_data}), 64'({1'b1, 45'(32'h5000 + i)}));
      applyStimulus();
    end
    check("rxovf empty", 64'(rx_valid), 64'(0));

    // RX full with a pop at the same edge as a new arrival: nothing is dropped.
    $display("[TB] RX full with simultaneous pop");
    rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din_leaf = {1'b1, 3'd0, 45'(32'h6000 + i)};
      applyStimulus();
    end
    rx_ready = 1'b1;
    din_leaf = {1'b1, 3'd7, 45'h6FFF};
    applyStimulus();
    din_leaf = '0;
    check("rxsim drop_cnt", 64'(rx_drop_cnt), 64'(2));
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("rxsim drain %0d", i), 64'({rx_valid, rx_data}),
            64'({1'b1, (i == 16) ? 45'h6FFF : 45'(32'h6000 + i)}));
      applyStimulus();
    end
    check("rxsim empty", 64'(rx_valid), 64'(0));

    // Random traffic with occasional mid-operation reset.
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      randomInputs();
      reset = ($urandom_range(63) == 0);
      applyStimulus();
    end
    reset = 1'b0;
    idleInputs();
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
